mesh_router_xy: RTL

MESH_ROUTER_XY -- requirements
Module: mesh_router_xy

---
 rtl/noc_pkg.sv | 18 +
 rtl/noc_fifo.sv | 48 ++++
 rtl/mesh_router_xy.sv | 115 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: port indices, default flit width and the XY routing rule shared by the mesh NoC
package noc_pkg;
  typedef logic [2:0] port_t;
  localparam int    NUM_PORTS          = 5;
  localparam port_t P_LOCAL            = 3'd0;
  localparam port_t P_NORTH            = 3'd1;
  localparam port_t P_EAST             = 3'd2;
  localparam port_t P_SOUTH            = 3'd3;
  localparam port_t P_WEST             = 3'd4;
  localparam int    DEFAULT_DATA_WIDTH = 32;
  // Dimension-ordered routing: close the X distance first, then Y, then deliver locally.
  function automatic port_t xy_route(input int dst_x, input int dst_y, input int x_addr, input int y_addr);
    return dst_x > x_addr ? P_EAST  :
           dst_x < x_addr ? P_WEST  :
           dst_y > y_addr ? P_SOUTH :
           dst_y < y_addr ? P_NORTH : P_LOCAL;
  endfunction
endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: show-ahead input FIFO; head entry is visible on data_o whenever empty_o is low
module noc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Next pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // Storage is left unreset; only pointers and count define occupancy.
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  // Occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mesh_router_xy.sv
// mesh_router_xy: 5-port XY mesh router with input FIFOs, per-output round-robin and registered outputs
module mesh_router_xy
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 2,
  parameter int X_ADDR     = 0,
  parameter int Y_ADDR     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_full,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_full,
  output logic                            err_drop
);
  localparam int XW = MESH_X > 1 ? $clog2(MESH_X) : 1;
  localparam int YW = MESH_Y > 1 ? $clog2(MESH_Y) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_WIDTH-1:0] head [NUM_PORTS];
  logic [CW-1:0]         fifo_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]  fifo_empty, req_vld, drop, pop, can_load, gnt_vld;
  logic [NUM_PORTS-1:0]  out_valid_q, out_valid_d;
  port_t                 dst_port [NUM_PORTS];
  port_t                 gnt_idx [NUM_PORTS];
  port_t                 rr_q [NUM_PORTS];
  port_t                 rr_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] out_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] out_data_d [NUM_PORTS];
  logic                  err_drop_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    noc_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (in_valid[g]),
      .data_i  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i   (pop[g]),
      .data_o  (head[g]),
      .full_o  (in_full[g]),
      .empty_o (fifo_empty[g]),
      .count_o (fifo_cnt[g])
    );
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = out_data_q[g];
    // Occupancy can never exceed the FIFO depth.
    always_ff @(posedge clk)
      if (rst_n) assert (fifo_cnt[g] <= CW'(FIFO_DEPTH));
  end

  // Classify each head flit: a request to exactly one output, or an off-mesh drop.
  always_comb begin
    int dx, dy;
    logic bad;
    dx  = 0;
    dy  = 0;
    bad = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      dx          = int'(head[p][XW-1:0]);
      dy          = int'(head[p][XW+YW-1:XW]);
      bad         = dx >= MESH_X || dy >= MESH_Y;
      drop[p]     = !fifo_empty[p] && bad;
      req_vld[p]  = !fifo_empty[p] && !bad;
      dst_port[p] = xy_route(dx, dy, X_ADDR, Y_ADDR);
    end
  end

  // Per-output round-robin starting at rr_q; a stalled output grants nobody.
  always_comb begin
    int idx;
    idx = 0;
    pop = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      can_load[o] = !out_valid_q[o] || !out_full[o];
      gnt_vld[o]  = 1'b0;
      gnt_idx[o]  = P_LOCAL;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (int'(rr_q[o]) + k) % NUM_PORTS;
        if (can_load[o] && !gnt_vld[o] && req_vld[idx] && dst_port[idx] == port_t'(o)) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = port_t'(idx);
        end
      end
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
      rr_d[o]        = gnt_vld[o] ? (gnt_idx[o] == P_WEST ? P_LOCAL : gnt_idx[o] + port_t'(1)) : rr_q[o];
      out_valid_d[o] = can_load[o] ? gnt_vld[o] : out_valid_q[o];
      out_data_d[o]  = gnt_vld[o] ? head[gnt_idx[o]] : out_data_q[o];
    end
  end

  // Output stage, arbiter pointers and the drop flag.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= '0;
      err_drop_q  <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= '0;
        rr_q[o]       <= P_LOCAL;
      end
    end else begin
      out_valid_q <= out_valid_d;
      err_drop_q  <= |drop;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= out_data_d[o];
        rr_q[o]       <= rr_d[o];
      end
    end

  assign out_valid = out_valid_q;
  assign err_drop  = err_drop_q;
endmodule
